// File: rtl/wisc_pkg.sv
// Shared definitions: opcodes, branch condition codes, flag bit positions
// and the flag-update class of each opcode.
package wisc_pkg;

    // Opcodes
    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b0001;
    localparam logic [3:0] OP_XOR    = 4'b0010;
    localparam logic [3:0] OP_RED    = 4'b0011;
    localparam logic [3:0] OP_SLL    = 4'b0100;
    localparam logic [3:0] OP_SRA    = 4'b0101;
    localparam logic [3:0] OP_ROR    = 4'b0110;
    localparam logic [3:0] OP_PADDSB = 4'b0111;
    localparam logic [3:0] OP_LW     = 4'b1000;
    localparam logic [3:0] OP_SW     = 4'b1001;
    localparam logic [3:0] OP_LLB    = 4'b1010;
    localparam logic [3:0] OP_LHB    = 4'b1011;
    localparam logic [3:0] OP_B      = 4'b1100;
    localparam logic [3:0] OP_BR     = 4'b1101;
    localparam logic [3:0] OP_PCS    = 4'b1110;
    localparam logic [3:0] OP_HLT    = 4'b1111;

    // Branch condition codes
    localparam logic [2:0] CC_NEQ    = 3'b000;
    localparam logic [2:0] CC_EQ     = 3'b001;
    localparam logic [2:0] CC_GT     = 3'b010;
    localparam logic [2:0] CC_LT     = 3'b011;
    localparam logic [2:0] CC_GTE    = 3'b100;
    localparam logic [2:0] CC_LTE    = 3'b101;
    localparam logic [2:0] CC_OVFL   = 3'b110;
    localparam logic [2:0] CC_UNCOND = 3'b111;

    // Bit positions inside the {Z,V,N} flag vector
    localparam int FLG_Z = 2;
    localparam int FLG_V = 1;
    localparam int FLG_N = 0;

    // Which flags an opcode writes
    typedef enum logic [1:0] {
        FC_NONE   = 2'd0,
        FC_Z_ONLY = 2'd1,
        FC_ZVN    = 2'd2
    } flag_class_e;

    // Arithmetic ops write all three flags; logic/shift ops write Z only.
    // Memory and PC ops use the adder but never touch flags.
    function automatic flag_class_e flag_class(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB:                 flag_class = FC_ZVN;
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: flag_class = FC_Z_ONLY;
            default:                        flag_class = FC_NONE;
        endcase
    endfunction

endpackage

// File: rtl/flag_branch_unit_cond.sv
// Pure combinational branch condition evaluator on a {Z,V,N} flag vector.
module branch_cond
    import wisc_pkg::*;
(
    input  logic [2:0] ccc,
    input  logic [2:0] flags,
    output logic       taken
);

    logic z, v, n;

    assign z = flags[FLG_Z];
    assign v = flags[FLG_V];
    assign n = flags[FLG_N];

    // Decode the condition code against the flags
    always_comb begin
        taken = 1'b0;
        case (ccc)
            CC_NEQ:    taken = ~z;
            CC_EQ:     taken = z;
            CC_GT:     taken = ~z & ~n;
            CC_LT:     taken = n;
            CC_GTE:    taken = z | (~z & ~n);
            CC_LTE:    taken = n | z;
            CC_OVFL:   taken = v;
            CC_UNCOND: taken = 1'b1;
            default:   taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_branch_unit.sv
// Architectural Z/V/N flag register with a zero-bubble forward path from EX
// into the ID-stage branch condition evaluation.
module flag_branch_unit
    import wisc_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic              ex_stall,
    input  logic [3:0]        ex_opcode,
    input  logic [DATA_W-1:0] ex_alu_out,
    input  logic              ex_zero,
    input  logic              ex_ovfl,
    input  logic              id_is_branch,
    input  logic [2:0]        id_ccc,
    output logic              branch_taken,
    output logic [2:0]        flags_q
);

    flag_class_e fclass;
    logic        we;
    logic [2:0]  new_flags;
    logic [2:0]  eff;
    logic        cond_taken;

    // Only the sign bit of the ALU result matters here
    logic unused_alu_bits;
    assign unused_alu_bits = ^ex_alu_out[DATA_W-2:0];

    // Classify the EX op, merge its new flags over the held ones, and pick
    // the forwarded value. A stalled EX op is re-presented later, so it is
    // neither written nor forwarded now.
    always_comb begin
        fclass    = flag_class(ex_opcode);
        we        = ex_valid & ~ex_stall & (fclass != FC_NONE);
        new_flags = flags_q;
        case (fclass)
            FC_ZVN: begin
                new_flags[FLG_Z] = ex_zero;
                new_flags[FLG_V] = ex_ovfl;
                new_flags[FLG_N] = ex_alu_out[DATA_W-1];
            end
            FC_Z_ONLY: new_flags[FLG_Z] = ex_zero;
            default:   new_flags = flags_q;
        endcase
        eff = we ? new_flags : flags_q;
    end

    // Flag register; reset wins over a simultaneous write
    always_ff @(posedge clk) begin
        if (rst)
            flags_q <= 3'b000;
        else if (we)
            flags_q <= new_flags;
    end

    branch_cond u_cond (
        .ccc   (id_ccc),
        .flags (eff),
        .taken (cond_taken)
    );

    assign branch_taken = id_is_branch & cond_taken;

endmodule

// File: doc/flag_branch_unit.md
# flag_branch_unit

Consumes the EX-stage ALU result and raw overflow indication, and maintains the architectural Z/V/N flag register according to per-opcode update rules. In the ID stage it evaluates the 3-bit branch condition code of B/BR against the flags. When the instruction in EX writes flags, the freshly computed flags are forwarded to that evaluation, so a compare-then-branch pair resolves without a bubble. It sits between the EX stage (ALU outputs, pipeline control) and the ID-stage branch/PC logic.

## Interface
- `DATA_W`, 16, ALU result width; N is taken from bit `DATA_W-1`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ex_valid` in 1: EX holds a real (non-bubble) instruction.
- `ex_stall` in 1: EX is held this cycle; no flag write.
- `ex_opcode` in 4: opcode of the EX instruction.
- `ex_alu_out` in 16: ALU result, already saturated.
- `ex_zero` in 1: ALU zero indication.
- `ex_ovfl` in 1: raw ALU overflow (adder/RED overflow).
- `id_is_branch` in 1: ID holds B (1100) or BR (1101).
- `id_ccc` in 3: branch condition code.
- `branch_taken` out 1: combinational condition result; 0 when `id_is_branch`=0.
- `flags_q` out 3: registered flags {Z,V,N}; reset value 3'b000.

## Operation
- Flag write enable: `we = ex_valid & ~ex_stall & class(ex_opcode)`.
- ADD (0000) and SUB (0001) write Z, V and N:
  - Z = `ex_zero`.
  - V = `ex_ovfl`.
  - N = `ex_alu_out[15]`, taken from the saturated value. Positive saturation to 0x7FFF therefore gives N=0.
- XOR (0010), SLL (0100), SRA (0101) and ROR (0110) write Z only; V and N keep their old values.
- All other opcodes write nothing: RED, PADDSB, LW, SW, LLB, LHB, B, BR, PCS, HLT. LW/SW/PCS use the ALU adder but must not touch flags.
- Effective flags: `eff = we ? {new flags merged with held bits} : flags_q`.
- Condition evaluation on `eff`:
  - 000 NEQ: Z=0.
  - 001 EQ: Z=1.
  - 010 GT: Z=0 & N=0.
  - 011 LT: N=1.
  - 100 GTE: Z=1 | (Z=0 & N=0).
  - 101 LTE: N=1 | Z=1.
  - 110 OVFL: V=1.
  - 111 always taken.
- `branch_taken = id_is_branch & cond(id_ccc, eff)`.
- Flush of EX is presented upstream as `ex_valid`=0; no separate flush port.

## Timing
- `flags_q` updates on the rising edge after `we`=1. Latency from EX result to `flags_q` is 1 cycle.
- Forward path is 0 cycles: a branch in ID sees the flags of the instruction concurrently in EX.
- `ex_stall`=1: `flags_q` holds. The forward path is also suppressed (`eff = flags_q`), because the EX instruction will be re-presented.
- `rst`=1 at an edge: `flags_q` ← 000 regardless of `we`; reset wins over a simultaneous write.
- `branch_taken` during reset is still combinational on inputs and `flags_q`. Downstream ignores it while `rst`=1.
- Back-to-back flag writers: each edge captures the newest; no accumulation beyond the bit-merge rule.
- Z-only writer followed by a branch on LT: N comes from the older ADD/SUB in `flags_q`.

## Structure
- A shared package `wisc_pkg` holds:
  - Opcode constants: OP_ADD…OP_HLT.
  - CCC constants: CC_NEQ…CC_UNCOND.
  - Flag bit indices: FLG_Z=2, FLG_V=1, FLG_N=0.
  - A 2-bit flag-class enum: NONE, Z_ONLY, ZVN.
- One sub-module, `branch_cond`: purely combinational, mapping `ccc` and {Z,V,N} to `taken`.
- Flag register, opcode classifier and forwarding mux stay in the top module.

## Test plan
- **Reset:** `rst`=1 for 2 cycles with ADD `we` active → `flags_q`=000. Then branch ccc=001 (EQ) → `branch_taken`=0.
- **Saturating ADD:** ADD with `ex_alu_out`=0x7FFF, `ex_ovfl`=1, `ex_zero`=0 → next `flags_q`={0,1,0}. Same-cycle branch ccc=110 → `branch_taken`=1 via forward.
- **Z-only update:** SUB giving 0x8000 → {0,0,1}. Then XOR giving 0x0000 → {1,0,1}. Then ccc=101 → taken=1; ccc=010 → taken=0.
- **Non-writers:** LW with `ex_alu_out`=0x0000, `ex_zero`=1 → `flags_q` unchanged. Same for PCS and PADDSB.
- **Stall:** SUB with `ex_zero`=1 and `ex_stall`=1 for 3 cycles → `flags_q` held and branch EQ uses old Z. Releasing the stall → Z=1 after 1 edge.
- **Bubble and unconditional:** `ex_valid`=0 with an ADD opcode → no write. `id_is_branch`=0 with ccc=111 → `branch_taken`=0. `id_is_branch`=1 with ccc=111 → 1.
